// File: rtl/alu_16bit.sv
// Registered integer ALU: add, subtract, AND, OR and XOR on two WIDTH-bit operands.
// The result and the carry/zero/negative/overflow flags are captured on the rising clock
// edge. A new operation is accepted every cycle and appears one cycle later.
module alu_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] C,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int MSB = WIDTH - 1;

    // Operation select codes; the three codes not listed here are reserved.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b111;

    // Arithmetic is done one bit wider so the top bit holds carry-out or borrow.
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;

    // Bitwise results, built per bit.
    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] xor_bits;

    // Signed overflow candidates for the two arithmetic operations.
    logic             add_ovf;
    logic             sub_ovf;

    // Next-state values for the output registers.
    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic             overflow_next;
    logic             zero_next;
    logic             negative_next;

    // Output registers.
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             zero_reg;
    logic             negative_reg;
    logic             overflow_reg;

    // In the wide difference, bit WIDTH is set exactly when A < B (unsigned), i.e. a borrow.
    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_bits[gi] = A[gi] & B[gi];
            assign or_bits[gi]  = A[gi] | B[gi];
            assign xor_bits[gi] = A[gi] ^ B[gi];
        end
    endgenerate

    // Add overflows when both operands share a sign and the result does not.
    // Subtract overflows when the operand signs differ and the result sign differs from A.
    assign add_ovf = (A[MSB] == B[MSB]) && (sum_ext[MSB]  != A[MSB]);
    assign sub_ovf = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);

    // Select the result and flags for the requested operation; reserved codes give all zero.
    always_comb begin
        result_next   = '0;
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        case (sel)
            OP_ADD: begin
                result_next   = sum_ext[WIDTH-1:0];
                carry_next    = sum_ext[WIDTH];
                overflow_next = add_ovf;
            end
            OP_SUB: begin
                result_next   = diff_ext[WIDTH-1:0];
                carry_next    = diff_ext[WIDTH];
                overflow_next = sub_ovf;
            end
            OP_AND:  result_next = and_bits;
            OP_OR:   result_next = or_bits;
            OP_XOR:  result_next = xor_bits;
            default: result_next = '0;
        endcase
        zero_next     = (result_next == '0);
        negative_next = result_next[MSB];
    end

    // Capture the result and flags each edge; a low rst_n clears everything, operands ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg   <= '0;
            carry_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            negative_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            result_reg   <= result_next;
            carry_reg    <= carry_next;
            zero_reg     <= zero_next;
            negative_reg <= negative_next;
            overflow_reg <= overflow_next;
        end
    end

    assign C        = result_reg;
    assign carry    = carry_reg;
    assign zero     = zero_reg;
    assign negative = negative_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: directed cases plus randomized vectors compared
// against an arithmetic reference model.
module tb_alu_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  sel;
    logic [15:0] C;
    logic        carry;
    logic        zero;
    logic        negative;
    logic        overflow;

    int total;
    int bad;

    alu_16bit #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .sel      (sel),
        .C        (C),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer arithmetic on unsigned and signed views of the operands.
    // Packs the expected outputs as {C, carry, zero, negative, overflow}.
    function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] s);
        int          ua;
        int          ub;
        int          sa;
        int          sb;
        int          r;
        int          sr;
        logic [15:0] c;
        logic        cy;
        logic        ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = 16'h0000;
        cy = 1'b0;
        ov = 1'b0;
        case (s)
            3'b000: begin
                r  = ua + ub;
                c  = 16'(r % 65536);
                cy = (r > 65535);
                sr = sa + sb;
                ov = (sr > 32767) || (sr < -32768);
            end
            3'b001: begin
                r  = ua - ub + 65536;
                c  = 16'(r % 65536);
                cy = (ua < ub);
                sr = sa - sb;
                ov = (sr > 32767) || (sr < -32768);
            end
            3'b010: c = a & b;
            3'b011: c = a | b;
            3'b111: c = a ^ b;
            default: c = 16'h0000;
        endcase
        return {c, cy, (c == 16'h0000), (c >= 16'h8000), ov};
    endfunction

    // Present operands away from the active edge, then wait for the capturing edge.
    task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] s);
        @(negedge clk);
        rst_n = r;
        A     = a;
        B     = b;
        sel   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] exp;
        step(1'b0, 16'h1234, 16'h1111, 3'b000);
        total++;
        if ({C, carry, zero, negative, overflow} !== 20'h00000) begin
            bad++;
            $display("FAIL reset: got C=%h c=%b z=%b n=%b v=%b, want all zero",
                     C, carry, zero, negative, overflow);
        end else $display("ok reset: C=%h flags=%b%b%b%b", C, carry, zero, negative, overflow);
        step(1'b1, 16'h1234, 16'h1111, 3'b000);
        exp = {16'h2345, 1'b0, 1'b0, 1'b0, 1'b0};
        total++;
        if ({C, carry, zero, negative, overflow} !== exp) begin
            bad++;
            $display("FAIL reset_release: got C=%h c=%b z=%b n=%b v=%b, want C=2345 flags 0000",
                     C, carry, zero, negative, overflow);
        end else $display("ok reset_release: C=%h", C);
    endtask

    task automatic test_add();
        logic [15:0] ta [2] = '{16'hFFFF, 16'h7FFF};
        logic [15:0] tb [2] = '{16'h0001, 16'h0001};
        logic [19:0] te [2] = '{{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0},
                                {16'h8000, 1'b0, 1'b0, 1'b1, 1'b1}};
        for (int i = 0; i < 2; i++) begin
            step(1'b1, ta[i], tb[i], 3'b000);
            total++;
            if ({C, carry, zero, negative, overflow} !== te[i]) begin
                bad++;
                $display("FAIL add_%0d: got {C,c,z,n,v}=%h want %h", i,
                         {C, carry, zero, negative, overflow}, te[i]);
            end else $display("ok add %h+%h: C=%h c=%b v=%b", ta[i], tb[i], C, carry, overflow);
        end
    endtask

    task automatic test_sub();
        logic [15:0] ta [2] = '{16'h0005, 16'h8000};
        logic [15:0] tb [2] = '{16'h0007, 16'h0001};
        logic [19:0] te [2] = '{{16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0},
                                {16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1}};
        for (int i = 0; i < 2; i++) begin
            step(1'b1, ta[i], tb[i], 3'b001);
            total++;
            if ({C, carry, zero, negative, overflow} !== te[i]) begin
                bad++;
                $display("FAIL sub_%0d: got {C,c,z,n,v}=%h want %h", i,
                         {C, carry, zero, negative, overflow}, te[i]);
            end else $display("ok sub %h-%h: C=%h c=%b v=%b", ta[i], tb[i], C, carry, overflow);
        end
    endtask

    task automatic test_logic();
        logic [2:0]  ts [3] = '{3'b010, 3'b011, 3'b111};
        logic [15:0] tc [3] = '{16'h00F0, 16'hFFF0, 16'hFF00};
        logic [19:0] exp;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'hF0F0, 16'h0FF0, ts[i]);
            exp = {tc[i], 1'b0, 1'b0, tc[i][15], 1'b0};
            total++;
            if ({C, carry, zero, negative, overflow} !== exp) begin
                bad++;
                $display("FAIL logic_sel%b: got {C,c,z,n,v}=%h want %h", ts[i],
                         {C, carry, zero, negative, overflow}, exp);
            end else $display("ok logic sel=%b: C=%h", ts[i], C);
        end
    endtask

    task automatic test_reserved();
        logic [2:0] ts [3] = '{3'b100, 3'b101, 3'b110};
        for (int i = 0; i < 3; i++) begin
            // Load a nonzero result first so a stale value cannot pass.
            step(1'b1, 16'hABCD, 16'h1234, 3'b011);
            step(1'b1, 16'hABCD, 16'h1234, ts[i]);
            total++;
            if ({C, carry, zero, negative, overflow} !== {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reserved_sel%b: got C=%h c=%b z=%b n=%b v=%b, want C=0000 z=1",
                         ts[i], C, carry, zero, negative, overflow);
            end else $display("ok reserved sel=%b: C=%h z=%b", ts[i], C, zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        step(1'b1, 16'h4000, 16'h4000, 3'b000);
        exp = ref_model(16'h4000, 16'h4000, 3'b000);
        total++;
        if ({C, carry, zero, negative, overflow} !== exp) begin
            bad++;
            $display("FAIL b2b_pre: got %h want %h", {C, carry, zero, negative, overflow}, exp);
        end else $display("ok b2b_pre: C=%h v=%b", C, overflow);
        step(1'b0, 16'hFFFF, 16'hFFFF, 3'b000);
        total++;
        if ({C, carry, zero, negative, overflow} !== 20'h00000) begin
            bad++;
            $display("FAIL b2b_reset: got %h want 00000", {C, carry, zero, negative, overflow});
        end else $display("ok b2b_reset: C=%h", C);
        step(1'b1, 16'h0003, 16'h0009, 3'b001);
        exp = ref_model(16'h0003, 16'h0009, 3'b001);
        total++;
        if ({C, carry, zero, negative, overflow} !== exp) begin
            bad++;
            $display("FAIL b2b_post: got %h want %h", {C, carry, zero, negative, overflow}, exp);
        end else $display("ok b2b_post: C=%h c=%b", C, carry);
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  s;
        logic [19:0] exp;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 3'($urandom_range(0, 7));
            step(1'b1, a, b, s);
            exp = ref_model(a, b, s);
            total++;
            if ({C, carry, zero, negative, overflow} !== exp) begin
                bad++;
                $display("FAIL random_%0d: A=%h B=%h sel=%b got {C,c,z,n,v}=%h want %h",
                         i, a, b, s, {C, carry, zero, negative, overflow}, exp);
                break;
            end else $display("ok random %0d: A=%h B=%h sel=%b C=%h", i, a, b, s, C);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        A     = 16'h0000;
        B     = 16'h0000;
        sel   = 3'b000;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_reserved();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
